// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
// Shared types and constants for the seven-segment display path.
//   phase_t        : scan phase within one digit slot (blank gap / lit)
//   AN_OFF         : anode pattern with every digit off (anodes are active-low)
//   liro_t         : LIRO state codes
//   DIG_*          : non-numeric digit codes (10..14) understood by sevenseg_control
//   dim_on_cycles  : lit cycles per slot when dimming is active
// -----------------------------------------------------------------------------
package sevenseg_pkg;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        LIRO_00 = 2'b00,
        LIRO_01 = 2'b01,
        LIRO_10 = 2'b10,
        LIRO_11 = 2'b11
    } liro_t;

    // Letter/symbol codes placed after the decimal digits 0..9.
    localparam logic [3:0] DIG_L    = 4'd10;
    localparam logic [3:0] DIG_I    = 4'd11;
    localparam logic [3:0] DIG_R    = 4'd12;
    localparam logic [3:0] DIG_O    = 4'd13;
    localparam logic [3:0] DIG_DASH = 4'd14;

    // A quarter of the non-blank part of a slot, never less than one cycle.
    function automatic int dim_on_cycles(input int refresh_div, input int blank_cycles);
        int w;
        w = (refresh_div - blank_cycles) / 4;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sevenseg_scan_scheduler_hold_timer.sv
// -----------------------------------------------------------------------------
// display_hold_timer
// Decides which source owns the display. A request from source B is remembered
// until the next frame boundary; at that boundary B takes over for HOLD_FRAMES
// frames, counted from the last accepted request.
// Ports:
//   CLK, RST         : clock, asynchronous active-high reset
//   i_req            : source B request, sampled every clock
//   i_boundary       : high in the cycle whose closing edge starts a new frame
//   o_src_sel        : registered selection (0 = A, 1 = B)
//   o_src_sel_next   : selection that takes effect on the coming edge, so the
//                      frame latch can load from the right source on that edge
// -----------------------------------------------------------------------------
module display_hold_timer #(
    parameter int HOLD_FRAMES = 500
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_req,
    input  logic i_boundary,
    output logic o_src_sel,
    output logic o_src_sel_next
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_FRAMES - 1);

    logic          r_pend;
    logic [HW-1:0] r_hold;
    logic          w_pend_next;
    logic [HW-1:0] w_hold_next;
    logic          w_src_next;

    always_comb begin
        w_pend_next = r_pend;
        w_hold_next = r_hold;
        w_src_next  = o_src_sel;
        if (i_boundary) begin
            // A request landing on the boundary edge itself is taken right away.
            if (r_pend || i_req) begin
                w_src_next  = 1'b1;
                w_hold_next = HOLD_RELOAD;
                w_pend_next = 1'b0;
            end else if (r_hold != '0) begin
                w_hold_next = r_hold - HW'(1);
            end else begin
                w_src_next = 1'b0;
            end
        end else if (i_req) begin
            w_pend_next = 1'b1;
        end
    end

    assign o_src_sel_next = w_src_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pend    <= 1'b0;
            r_hold    <= '0;
            o_src_sel <= 1'b0;
        end else begin
            r_pend    <= w_pend_next;
            r_hold    <= w_hold_next;
            o_src_sel <= w_src_next;
        end
    end

endmodule

// File: rtl/sevenseg_scan_scheduler.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_scheduler
// Scans a 4-digit seven-segment display. Each digit slot is REFRESH_DIV clocks:
// the first BLANK_CYCLES have every anode off (anti-ghosting gap), the rest light
// the digit selected by anode_count. Every 4 slots form a frame; the displayed
// value and LIRO state are latched once per frame from source A or source B.
// Optional feature (macro SEG_DIM_EN): adds input dim which shortens the lit
// part of each slot to a quarter of its normal length.
// Ports:
//   CLK, RST              : clock, asynchronous active-high reset
//   num_a, state_a        : source A value / LIRO state
//   num_b, state_b, req_b : source B value / LIRO state / request
//   dim                   : (SEG_DIM_EN only) dimming enable
//   anode_count           : digit index for sevenseg_control
//   an                    : active-low anodes
//   frame_num/frame_state : value and state latched for the current frame
//   frame_start           : pulse in the first cycle of each frame
//   src_sel               : 0 = A shown, 1 = B shown
// All outputs are registered.
// -----------------------------------------------------------------------------
module sevenseg_scan_scheduler
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 25000,
    parameter int BLANK_CYCLES = 500,
    parameter int HOLD_FRAMES  = 500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] num_a,
    input  logic [1:0] state_a,
    input  logic [3:0] num_b,
    input  logic [1:0] state_b,
    input  logic       req_b,
`ifdef SEG_DIM_EN
    input  logic       dim,
`endif
    output logic [1:0] anode_count,
    output logic [3:0] an,
    output logic [3:0] frame_num,
    output logic [1:0] frame_state,
    output logic       frame_start,
    output logic       src_sel
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    phase_t           r_phase;

    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_ac_next;
    phase_t           w_phase_next;
    logic             w_slot_end;
    logic             w_boundary;
    logic             w_lit;
    logic             w_sel_next;
    logic [3:0]       w_an_on;

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_boundary = w_slot_end && (anode_count == 2'd3);
    assign w_cnt_next = w_slot_end ? '0 : r_cnt + CNT_W'(1);
    assign w_ac_next  = w_slot_end ? anode_count + 2'd1 : anode_count;

    // Outputs are registered from the next-state values so that an and
    // anode_count line up with the counter in the same cycle.
    always_comb begin
        w_phase_next = r_phase;
        case (r_phase)
            PH_BLANK: if (w_cnt_next == BLANK_C) w_phase_next = PH_ON;
            PH_ON:    if (w_slot_end)            w_phase_next = PH_BLANK;
            default:  w_phase_next = PH_BLANK;
        endcase
    end

`ifdef SEG_DIM_EN
    localparam int DIM_END = BLANK_CYCLES + dim_on_cycles(REFRESH_DIV, BLANK_CYCLES);
    localparam logic [CNT_W:0] DIM_END_C = (CNT_W + 1)'(DIM_END);
    assign w_lit = (w_phase_next == PH_ON) && (!dim || ({1'b0, w_cnt_next} < DIM_END_C));
`else
    assign w_lit = (w_phase_next == PH_ON);
`endif

    // Active-low one-hot for the digit that will be selected after this edge.
    for (genvar gi = 0; gi < 4; gi++) begin : g_an
        assign w_an_on[gi] = (w_ac_next != 2'(gi));
    end

    display_hold_timer #(
        .HOLD_FRAMES(HOLD_FRAMES)
    ) u_hold (
        .CLK           (CLK),
        .RST           (RST),
        .i_req         (req_b),
        .i_boundary    (w_boundary),
        .o_src_sel     (src_sel),
        .o_src_sel_next(w_sel_next)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt       <= '0;
            r_phase     <= PH_BLANK;
            anode_count <= 2'd0;
            an          <= AN_OFF;
            frame_num   <= 4'd0;
            frame_state <= 2'b00;
            frame_start <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_phase     <= w_phase_next;
            anode_count <= w_ac_next;
            an          <= w_lit ? w_an_on : AN_OFF;
            frame_start <= w_boundary;
            if (w_boundary) begin
                frame_num   <= w_sel_next ? num_b   : num_a;
                frame_state <= w_sel_next ? state_b : state_a;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_scheduler.sv
module tb_sevenseg_scan_scheduler;

    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int HOLD   = 3;
    localparam int FRAME  = 4 * DIV;
    localparam int DIM_ON = ((DIV - BLANK) / 4 < 1) ? 1 : (DIV - BLANK) / 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] num_a = 4'd0;
    logic [1:0] state_a = 2'd0;
    logic [3:0] num_b = 4'd0;
    logic [1:0] state_b = 2'd0;
    logic       req_b = 1'b0;
    logic       dim_on = 1'b0;

    logic [1:0] anode_count;
    logic [3:0] an;
    logic [3:0] frame_num;
    logic [1:0] frame_state;
    logic       frame_start;
    logic       src_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycle index since reset release, frame of the last
    // accepted B request, and whether a request arrived in the current frame.
    int         t;
    int         last_acc;
    bit         req_win;
    logic [3:0] m_num;
    logic [1:0] m_state;
    logic       m_src;

    sevenseg_scan_scheduler #(
        .REFRESH_DIV (DIV),
        .BLANK_CYCLES(BLANK),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .num_a      (num_a),
        .state_a    (state_a),
        .num_b      (num_b),
        .state_b    (state_b),
        .req_b      (req_b),
`ifdef SEG_DIM_EN
        .dim        (dim_on),
`endif
        .anode_count(anode_count),
        .an         (an),
        .frame_num  (frame_num),
        .frame_state(frame_state),
        .frame_start(frame_start),
        .src_sel    (src_sel)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] exp_ac(input int tt);
        return 2'((tt / DIV) % 4);
    endfunction

    function automatic logic [3:0] exp_an(input int tt, input logic dm);
        int         pos;
        bit         lit;
        logic [3:0] one;
        pos = tt % DIV;
        one = 4'b0001;
        lit = (pos >= BLANK) && (!dm || pos < BLANK + DIM_ON);
        return lit ? ~(one << ((tt / DIV) % 4)) : 4'b1111;
    endfunction

    function automatic logic exp_fs(input int tt);
        return (tt > 0) && (tt % FRAME == 0);
    endfunction

    task automatic model_reset();
        t        = 0;
        last_acc = -100;
        req_win  = 1'b0;
        m_num    = 4'd0;
        m_state  = 2'd0;
        m_src    = 1'b0;
    endtask

    // Advance one clock; the model sees the inputs as they were at the edge.
    task automatic tick();
        logic       s_req;
        logic [3:0] s_na, s_nb;
        logic [1:0] s_sa, s_sb;
        int         f;
        s_req = req_b; s_na = num_a; s_nb = num_b; s_sa = state_a; s_sb = state_b;
        @(posedge CLK);
        t++;
        if (t % FRAME == 0) begin
            f = t / FRAME;
            if (req_win || s_req) last_acc = f;
            req_win = 1'b0;
            m_src   = (f - last_acc < HOLD);
            m_num   = m_src ? s_nb : s_na;
            m_state = m_src ? s_sb : s_sa;
        end else if (s_req) begin
            req_win = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got %b exp 1111", an); end
        n_checks++; if (anode_count !== 2'd0) begin n_fail++; $display("FAIL reset_ac got %0d exp 0", anode_count); end
        n_checks++; if (frame_num !== 4'd0) begin n_fail++; $display("FAIL reset_num got %0d exp 0", frame_num); end
        n_checks++; if (frame_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b exp 00", frame_state); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b exp 0", frame_start); end
        n_checks++; if (src_sel !== 1'b0) begin n_fail++; $display("FAIL reset_src got %b exp 0", src_sel); end
        $display("test_reset done, checks so far %0d", n_checks);
    endtask

    task automatic test_scan();
        do_reset();
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            tick();
            n_checks++;
            if ({anode_count, an, frame_start} !== {exp_ac(t), exp_an(t, dim_on), exp_fs(t)}) begin
                n_fail++;
                $display("FAIL scan t=%0d got ac=%0d an=%b fs=%b exp ac=%0d an=%b fs=%b",
                         t, anode_count, an, frame_start, exp_ac(t), exp_an(t, dim_on), exp_fs(t));
            end
        end
        $display("test_scan done, checks so far %0d", n_checks);
    endtask

    task automatic test_frame_latch();
        do_reset();
        while (t < 2 * FRAME) begin
            if (t == 12) begin num_a = 4'd9; state_a = 2'b10; end
            if (t == 40) begin num_a = 4'd3; state_a = 2'b01; end
            tick();
            n_checks++;
            if ({frame_num, frame_state} !== {m_num, m_state}) begin
                n_fail++;
                $display("FAIL latch t=%0d got num=%0d st=%b exp num=%0d st=%b", t, frame_num, frame_state, m_num, m_state);
            end
            if (t == 31 || t == 32) begin
                n_checks++;
                if (frame_num !== ((t == 32) ? 4'd9 : 4'd0)) begin
                    n_fail++;
                    $display("FAIL latch_edge t=%0d got num=%0d", t, frame_num);
                end
            end
        end
        $display("test_frame_latch done, checks so far %0d", n_checks);
    endtask

    task automatic test_hold_single();
        num_a = 4'd4; state_a = 2'b01; num_b = 4'd7; state_b = 2'b11;
        do_reset();
        while (t < 5 * FRAME) begin
            req_b = (t == 5);
            tick();
            n_checks++;
            if ({src_sel, frame_num, frame_state} !== {m_src, m_num, m_state}) begin
                n_fail++;
                $display("FAIL hold t=%0d got src=%b num=%0d st=%b exp src=%b num=%0d st=%b",
                         t, src_sel, frame_num, frame_state, m_src, m_num, m_state);
            end
            if (t == 32) begin
                n_checks++;
                if ({src_sel, frame_num, frame_state} !== {1'b1, 4'd7, 2'b11}) begin
                    n_fail++;
                    $display("FAIL hold_take got src=%b num=%0d st=%b exp 1 7 11", src_sel, frame_num, frame_state);
                end
            end
            if (t == 128) begin
                n_checks++;
                if ({src_sel, frame_num, frame_state} !== {1'b0, 4'd4, 2'b01}) begin
                    n_fail++;
                    $display("FAIL hold_release got src=%b num=%0d st=%b exp 0 4 01", src_sel, frame_num, frame_state);
                end
            end
        end
        req_b = 1'b0;
        $display("test_hold_single done, checks so far %0d", n_checks);
    endtask

    task automatic test_back_to_back();
        do_reset();
        while (t < 7 * FRAME) begin
            req_b = (t == 5) || (t == 70);
            tick();
            n_checks++;
            if (src_sel !== m_src) begin
                n_fail++;
                $display("FAIL rearm t=%0d got src=%b exp %b", t, src_sel, m_src);
            end
            if (t == 191 || t == 192) begin
                n_checks++;
                if (src_sel !== (t == 191)) begin
                    n_fail++;
                    $display("FAIL rearm_edge t=%0d got src=%b", t, src_sel);
                end
            end
        end
        req_b = 1'b0;
        $display("test_back_to_back done, checks so far %0d", n_checks);
    endtask

    task automatic test_boundary_req();
        do_reset();
        while (t < 5 * FRAME) begin
            req_b = (t == FRAME - 1);
            tick();
            n_checks++;
            if (src_sel !== m_src) begin
                n_fail++;
                $display("FAIL bnd_req t=%0d got src=%b exp %b", t, src_sel, m_src);
            end
            if (t == 32 || t == 128) begin
                n_checks++;
                if (src_sel !== (t == 32)) begin
                    n_fail++;
                    $display("FAIL bnd_req_edge t=%0d got src=%b", t, src_sel);
                end
            end
        end
        req_b = 1'b0;
        $display("test_boundary_req done, checks so far %0d", n_checks);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 16 * FRAME; i++) begin
            req_b = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) begin
                num_a = 4'($urandom_range(0, 15)); state_a = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) begin
                num_b = 4'($urandom_range(0, 15)); state_b = 2'($urandom_range(0, 3));
            end
            tick();
            n_checks++;
            if ({anode_count, an, frame_start, src_sel, frame_num, frame_state} !==
                {exp_ac(t), exp_an(t, dim_on), exp_fs(t), m_src, m_num, m_state}) begin
                n_fail++;
                $display("FAIL random t=%0d got ac=%0d an=%b fs=%b src=%b num=%0d st=%b exp ac=%0d an=%b fs=%b src=%b num=%0d st=%b",
                         t, anode_count, an, frame_start, src_sel, frame_num, frame_state,
                         exp_ac(t), exp_an(t, dim_on), exp_fs(t), m_src, m_num, m_state);
            end
        end
        req_b = 1'b0;
        $display("test_random done, checks so far %0d", n_checks);
    endtask

    task automatic test_async_reset();
        num_a = 4'd5; state_a = 2'b01; num_b = 4'd12; state_b = 2'b10;
        do_reset();
        while (t < FRAME + 20) begin
            req_b = (t == 3);
            tick();
        end
        req_b = 1'b0;
        n_checks++;
        if ({src_sel, frame_num, an} !== {m_src, m_num, exp_an(t, dim_on)}) begin
            n_fail++;
            $display("FAIL pre_rst got src=%b num=%0d an=%b exp src=%b num=%0d an=%b",
                     src_sel, frame_num, an, m_src, m_num, exp_an(t, dim_on));
        end
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({anode_count, an, frame_num, frame_state, frame_start, src_sel} !==
            {2'd0, 4'b1111, 4'd0, 2'b00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_rst got ac=%0d an=%b num=%0d st=%b fs=%b src=%b exp all reset",
                     anode_count, an, frame_num, frame_state, frame_start, src_sel);
        end
        do_reset();
        while (t < FRAME + 4) begin
            tick();
            n_checks++;
            if ({anode_count, an, frame_start, src_sel, frame_num, frame_state} !==
                {exp_ac(t), exp_an(t, dim_on), exp_fs(t), m_src, m_num, m_state}) begin
                n_fail++;
                $display("FAIL post_rst t=%0d got ac=%0d an=%b fs=%b src=%b num=%0d st=%b",
                         t, anode_count, an, frame_start, src_sel, frame_num, frame_state);
            end
        end
        $display("test_async_reset done, checks so far %0d", n_checks);
    endtask

`ifdef SEG_DIM_EN
    task automatic test_dim();
        dim_on = 1'b1;
        do_reset();
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            tick();
            n_checks++;
            if ({anode_count, an, frame_start} !== {exp_ac(t), exp_an(t, 1'b1), exp_fs(t)}) begin
                n_fail++;
                $display("FAIL dim t=%0d got ac=%0d an=%b fs=%b exp ac=%0d an=%b fs=%b",
                         t, anode_count, an, frame_start, exp_ac(t), exp_an(t, 1'b1), exp_fs(t));
            end
        end
        dim_on = 1'b0;
        $display("test_dim done, checks so far %0d", n_checks);
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_scan();
        test_frame_latch();
        test_hold_single();
        test_back_to_back();
        test_boundary_req();
        test_random();
        test_async_reset();
`ifdef SEG_DIM_EN
        test_dim();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
